// File: rtl/credit_pkg.sv
// rtl/credit_pkg.sv - shared state type, default sizing and parameter legality for credit_tracker
package credit_pkg;

  // Sender-side link states: INIT loads the pool, RUN trades credits, ERR traps an overflow
  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_MAX_CREDITS  = 15;
  localparam int DEF_INIT_CREDITS = 15;

  // Pool must fit in the counter, hold at least one credit, and start no fuller than capacity
  function automatic bit params_legal(input int width, input int max_credits,
                                      input int init_credits);
    return (width >= 1) && (width <= 30) &&
           (max_credits >= 1) && (max_credits <= (1 << width) - 1) &&
           (init_credits >= 0) && (init_credits <= max_credits);
  endfunction

endpackage

// File: rtl/credit_tracker.sv
// rtl/credit_tracker.sv - sender-side credit counter with send gating and sticky overflow trap
module credit_tracker
  import credit_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int MAX_CREDITS  = DEF_MAX_CREDITS,
  parameter int INIT_CREDITS = DEF_INIT_CREDITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_valid,
  output logic             send_ready,
  input  logic             cred_ret,
  output logic [WIDTH-1:0] cnt,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_CREDITS);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_CREDITS);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  if (!params_legal(WIDTH, MAX_CREDITS, INIT_CREDITS)) begin : g_param_check
    $error("credit_tracker: illegal WIDTH/MAX_CREDITS/INIT_CREDITS combination");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fire;

  // Sending is only possible in RUN with at least one credit; this is what prevents underflow
  assign send_ready = (state_q == RUN) && (cnt_q != '0);
  assign fire       = send_valid && send_ready;

  assign cnt   = cnt_q;
  assign err   = err_q;
  // INIT reports an empty, not-full pool regardless of what the counter decode would say
  assign empty = (state_q == INIT) || (cnt_q == '0);
  assign full  = (state_q != INIT) && (cnt_q == MAX_W);

  // Next-state: load pool after INIT, count sends down and returns up, trap a return into a full pool
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      INIT: begin
        state_d = RUN;
        cnt_d   = INIT_W;
      end
      RUN: begin
        if (fire && !cred_ret) begin
          cnt_d = cnt_q - ONE_W;
        end else if (!fire && cred_ret) begin
          if (cnt_q == MAX_W) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_W;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        // Unreachable encoding: park in the trap state rather than resume trading credits
        state_d = ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  // State, count and error flag registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_credit_tracker.sv
// tb/tb_credit_tracker.sv - randomized and directed checks of credit_tracker against a credit-pool model
module tb_credit_tracker;

  localparam int PH_UNKNOWN = -1;
  localparam int PH_INIT    = 0;
  localparam int PH_RUN     = 1;
  localparam int PH_ERR     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, send_valid, cred_ret;

  logic       a_ready, a_empty, a_full, a_err;
  logic [3:0] a_cnt;
  logic       b_ready, b_empty, b_full, b_err;
  logic [2:0] b_cnt;

  credit_tracker #(.WIDTH(4), .MAX_CREDITS(15), .INIT_CREDITS(15)) dut_a (
    .clk(clk), .rst(rst), .send_valid(send_valid), .send_ready(a_ready),
    .cred_ret(cred_ret), .cnt(a_cnt), .empty(a_empty), .full(a_full), .err(a_err)
  );

  credit_tracker #(.WIDTH(3), .MAX_CREDITS(5), .INIT_CREDITS(0)) dut_b (
    .clk(clk), .rst(rst), .send_valid(send_valid), .send_ready(b_ready),
    .cred_ret(cred_ret), .cnt(b_cnt), .empty(b_empty), .full(b_full), .err(b_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int a_fires  = 0;

  // Model: how many credits the sender holds, and which phase the link is in
  int a_cred = 0, a_ph = PH_UNKNOWN;
  int b_cred = 0, b_ph = PH_UNKNOWN;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_step(input int maxc, input int initc, input bit r,
                                     input bit sv, input bit cr,
                                     inout int cred, inout int ph);
    bit can_send;
    if (r) begin
      ph = PH_INIT;
      cred = 0;
    end else if (ph == PH_INIT) begin
      ph = PH_RUN;
      cred = initc;
    end else if (ph == PH_RUN) begin
      can_send = sv && (cred > 0);
      if (can_send && !cr) cred = cred - 1;
      else if (!can_send && cr) begin
        if (cred == maxc) ph = PH_ERR;
        else cred = cred + 1;
      end
    end
  endfunction

  // Advance both reference pools with the inputs seen at this edge
  always @(posedge clk) begin
    model_step(15, 15, rst, send_valid, cred_ret, a_cred, a_ph);
    model_step(5, 0, rst, send_valid, cred_ret, b_cred, b_ph);
  end

  // Compare every observable output of both instances mid-cycle
  always @(negedge clk) begin
    if (a_ph != PH_UNKNOWN) begin
      chk("a.cnt",        a_cnt,   (a_ph == PH_INIT) ? 0 : a_cred);
      chk("a.send_ready", a_ready, (a_ph == PH_RUN) && (a_cred > 0));
      chk("a.empty",      a_empty, (a_ph == PH_INIT) || (a_cred == 0));
      chk("a.full",       a_full,  (a_ph != PH_INIT) && (a_cred == 15));
      chk("a.err",        a_err,   a_ph == PH_ERR);
    end
    if (b_ph != PH_UNKNOWN) begin
      chk("b.cnt",        b_cnt,   (b_ph == PH_INIT) ? 0 : b_cred);
      chk("b.send_ready", b_ready, (b_ph == PH_RUN) && (b_cred > 0));
      chk("b.empty",      b_empty, (b_ph == PH_INIT) || (b_cred == 0));
      chk("b.full",       b_full,  (b_ph != PH_INIT) && (b_cred == 5));
      chk("b.err",        b_err,   b_ph == PH_ERR);
    end
  end

  // Apply inputs at a falling edge, let one rising edge consume them, return at the next falling edge
  task automatic tick(input bit r, input bit sv, input bit cr);
    rst = r;
    send_valid = sv;
    cred_ret = cr;
    if (!r && sv && a_ready === 1'b1) a_fires++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sv_pct, cr_pct;
    rst = 1'b1;
    send_valid = 1'b0;
    cred_ret = 1'b0;
    @(negedge clk);
    tick(1, 0, 0);

    chk("lit.init.cnt",   a_cnt, 0);
    chk("lit.init.ready", a_ready, 0);
    chk("lit.init.empty", a_empty, 1);
    chk("lit.init.full",  a_full, 0);
    chk("lit.init.err",   a_err, 0);

    tick(0, 0, 0);
    chk("lit.run.cnt",    a_cnt, 15);
    chk("lit.run.full",   a_full, 1);
    chk("lit.run.ready",  a_ready, 1);
    chk("lit.run.err",    a_err, 0);
    chk("lit.b.cnt",      b_cnt, 0);
    chk("lit.b.empty",    b_empty, 1);
    chk("lit.b.ready",    b_ready, 0);

    a_fires = 0;
    repeat (17) tick(0, 1, 0);
    chk("lit.drain.fires", a_fires, 15);
    chk("lit.drain.cnt",   a_cnt, 0);
    chk("lit.drain.empty", a_empty, 1);
    chk("lit.drain.ready", a_ready, 0);

    for (int i = 0; i < 13; i++) begin
      tick(0, 0, 1);
      if (i == 4) begin
        chk("lit.b.full5",  b_full, 1);
        chk("lit.b.cnt5",   b_cnt, 5);
        chk("lit.b.noerr",  b_err, 0);
      end
      if (i == 5) begin
        chk("lit.b.err6",   b_err, 1);
        chk("lit.b.hold6",  b_cnt, 5);
        chk("lit.b.ready6", b_ready, 0);
      end
    end
    chk("lit.refill.cnt13", a_cnt, 13);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("lit.refill.cnt15", a_cnt, 15);
    chk("lit.refill.full",  a_full, 1);
    chk("lit.refill.noerr", a_err, 0);
    tick(0, 0, 1);
    chk("lit.ovf.err",   a_err, 1);
    chk("lit.ovf.cnt",   a_cnt, 15);
    chk("lit.ovf.ready", a_ready, 0);
    repeat (4) tick(0, 1, 1);
    tick(0, 1, 0);
    tick(0, 0, 1);
    chk("lit.ovf.frozen", a_cnt, 15);
    chk("lit.ovf.sticky", a_err, 1);

    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("lit.sim.start", a_cnt, 15);
    repeat (5) tick(0, 1, 1);
    chk("lit.sim.full.cnt", a_cnt, 15);
    chk("lit.sim.full.err", a_err, 0);
    repeat (15) tick(0, 1, 0);
    chk("lit.sim.drained", a_cnt, 0);
    tick(0, 1, 1);
    chk("lit.sim.empty.cnt", a_cnt, 1);
    chk("lit.sim.empty.err", a_err, 0);

    repeat (6) tick(0, 0, 1);
    chk("lit.mid.cnt7", a_cnt, 7);
    tick(1, 1, 0);
    chk("lit.mid.rst.cnt",   a_cnt, 0);
    chk("lit.mid.rst.err",   a_err, 0);
    chk("lit.mid.rst.empty", a_empty, 1);
    chk("lit.mid.rst.ready", a_ready, 0);
    tick(0, 1, 0);
    chk("lit.mid.reload", a_cnt, 15);

    for (int w = 0; w < 8; w++) begin
      sv_pct = $urandom_range(10, 90);
      cr_pct = $urandom_range(10, 90);
      for (int i = 0; i < 400; i++) begin
        tick($urandom_range(0, 59) == 0,
             $urandom_range(0, 99) < sv_pct,
             $urandom_range(0, 99) < cr_pct);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
